// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage plus a carry flop, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic sum_bit;
    logic carry_out;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is x + ~y + 1: invert b and seed the carry.
                    a_d     = x;
                    b_d     = sub ? ~y : y;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                carry_d        = carry_out;
                acc_d          = acc_q >> 1;
                acc_d[WIDTH-1] = sum_bit;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = acc_d;
                    cout_d  = carry_out;
                    ovf_d   = carry_q ^ carry_out;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
